// File: rtl/load_use_hazard_ctrl.sv
// Load-use hazard controller: scoreboard of in-flight loads drives stall/flush
// decisions for the IF/ID stage and counts load-use stall cycles.
module load_use_hazard_ctrl #(
   parameter int REG_ADDR_W   = 5,
   parameter int LOAD_LATENCY = 1,
   parameter int CNT_W        = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  IFID_valid,
   input  logic [REG_ADDR_W-1:0] IFID_Reg_Rs1,
   input  logic [REG_ADDR_W-1:0] IFID_Reg_Rs2,
   input  logic                  IFID_Rs1_used,
   input  logic                  IFID_Rs2_used,
   input  logic [REG_ADDR_W-1:0] IFID_Reg_Rd,
   input  logic                  IFID_MemRead,
   input  logic                  Branch_taken,
   input  logic                  Pipe_freeze,
   output logic                  PC_write,
   output logic                  IFID_write,
   output logic                  IFID_flush,
   output logic                  Mux_select,
   output logic [CNT_W-1:0]      Stall_count
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic                  slot_v_q  [LOAD_LATENCY];
   logic [REG_ADDR_W-1:0] slot_rd_q [LOAD_LATENCY];
   logic [LOAD_LATENCY-1:0] slot_match;
   logic                  hazard;
   logic                  ins_v;
   logic [REG_ADDR_W-1:0] ins_rd;
   logic                  advance;
   logic [CNT_W-1:0]      stall_count_q, stall_count_d;

   logic rs1_live, rs2_live;
   assign rs1_live = IFID_Rs1_used && (IFID_Reg_Rs1 != '0);
   assign rs2_live = IFID_Rs2_used && (IFID_Reg_Rs2 != '0);

   genvar gi;
   generate
      for (gi = 0; gi < LOAD_LATENCY; gi++) begin : g_match
         assign slot_match[gi] = slot_v_q[gi] &&
            ((rs1_live && (IFID_Reg_Rs1 == slot_rd_q[gi])) ||
             (rs2_live && (IFID_Reg_Rs2 == slot_rd_q[gi])));
      end
   endgenerate

   assign hazard = IFID_valid && (|slot_match);

   always_comb begin
      PC_write      = 1'b1;
      IFID_write    = 1'b1;
      IFID_flush    = 1'b0;
      Mux_select    = 1'b0;
      ins_v         = 1'b0;
      ins_rd        = '0;
      advance       = 1'b1;
      stall_count_d = stall_count_q;
      if (Pipe_freeze) begin
         PC_write   = 1'b0;
         IFID_write = 1'b0;
         advance    = 1'b0;
      end else if (Branch_taken) begin
         IFID_flush = 1'b1;
         Mux_select = 1'b1;
      end else if (hazard) begin
         PC_write   = 1'b0;
         IFID_write = 1'b0;
         Mux_select = 1'b1;
         if (stall_count_q != CNT_MAX) begin
            stall_count_d = stall_count_q + 1'b1;
         end
      end else begin
         // Only a real load with a non-x0 destination occupies the scoreboard.
         ins_v  = IFID_valid && IFID_MemRead && (IFID_Reg_Rd != '0);
         ins_rd = IFID_Reg_Rd;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < LOAD_LATENCY; k++) begin
            slot_v_q[k]  <= 1'b0;
            slot_rd_q[k] <= '0;
         end
         stall_count_q <= '0;
      end else if (advance) begin
         // Oldest slot drops off: its result is forwardable from here on.
         for (int k = LOAD_LATENCY - 1; k > 0; k--) begin
            slot_v_q[k]  <= slot_v_q[k-1];
            slot_rd_q[k] <= slot_rd_q[k-1];
         end
         slot_v_q[0]   <= ins_v;
         slot_rd_q[0]  <= ins_rd;
         stall_count_q <= stall_count_d;
      end
   end

   assign Stall_count = stall_count_q;

endmodule

// File: tb/tb_load_use_hazard_ctrl.sv
// Bench for load_use_hazard_ctrl: directed scenarios then random traffic,
// checked against a per-register "cycles until forwardable" model.
module tb_load_use_hazard_ctrl;
   localparam int RW  = 5;
   localparam int LAT = 2;
   localparam int CW  = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          IFID_valid;
   logic [RW-1:0] IFID_Reg_Rs1, IFID_Reg_Rs2, IFID_Reg_Rd;
   logic          IFID_Rs1_used, IFID_Rs2_used, IFID_MemRead;
   logic          Branch_taken, Pipe_freeze;
   logic          PC_write, IFID_write, IFID_flush, Mux_select;
   logic [CW-1:0] Stall_count;

   load_use_hazard_ctrl #(.REG_ADDR_W(RW), .LOAD_LATENCY(LAT), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .IFID_valid(IFID_valid),
      .IFID_Reg_Rs1(IFID_Reg_Rs1), .IFID_Reg_Rs2(IFID_Reg_Rs2),
      .IFID_Rs1_used(IFID_Rs1_used), .IFID_Rs2_used(IFID_Rs2_used),
      .IFID_Reg_Rd(IFID_Reg_Rd), .IFID_MemRead(IFID_MemRead),
      .Branch_taken(Branch_taken), .Pipe_freeze(Pipe_freeze),
      .PC_write(PC_write), .IFID_write(IFID_write), .IFID_flush(IFID_flush),
      .Mux_select(Mux_select), .Stall_count(Stall_count)
   );

   always #5 clk = ~clk;

   // Model: remaining non-frozen cycles before each register's load result is forwardable.
   int ready_in [32];
   int cnt_m;
   int n_checks = 0;
   int n_pass = 0;
   int cyc_no = 0;
   bit haz_m;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc_no, obs, exp);
   endtask

   task automatic model_reset();
      for (int r = 0; r < 32; r++) ready_in[r] = 0;
      cnt_m = 0;
   endtask

   function automatic bit src_busy(input logic [RW-1:0] rs, input logic used);
      return used && (rs != 0) && (ready_in[rs] > 0);
   endfunction

   task automatic check_now();
      logic [3:0] e;
      haz_m = IFID_valid && (src_busy(IFID_Reg_Rs1, IFID_Rs1_used) ||
                             src_busy(IFID_Reg_Rs2, IFID_Rs2_used));
      if (Pipe_freeze)       e = 4'b0000;
      else if (Branch_taken) e = 4'b1111;
      else if (haz_m)        e = 4'b0001;
      else                   e = 4'b1100;
      chk("PC_write",   {31'd0, PC_write},   {31'd0, e[3]});
      chk("IFID_write", {31'd0, IFID_write}, {31'd0, e[2]});
      chk("IFID_flush", {31'd0, IFID_flush}, {31'd0, e[1]});
      chk("Mux_select", {31'd0, Mux_select}, {31'd0, e[0]});
      chk("Stall_count", {28'd0, Stall_count}, cnt_m);
   endtask

   // Inputs change at posedge+1, outputs checked at posedge+4, model steps at posedge.
   task automatic cyc();
      #3;
      check_now();
      @(posedge clk);
      if (!rst && !Pipe_freeze) begin
         for (int r = 0; r < 32; r++) if (ready_in[r] > 0) ready_in[r]--;
         if (!Branch_taken && haz_m) cnt_m = (cnt_m == CMAX) ? CMAX : cnt_m + 1;
         if (!Branch_taken && !haz_m && IFID_valid && IFID_MemRead && IFID_Reg_Rd != 0)
            ready_in[IFID_Reg_Rd] = LAT;
      end
      cyc_no++;
      #1;
   endtask

   task automatic areset();
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      check_now();
      @(posedge clk);
      cyc_no++;
      #1;
      rst = 1'b0;
   endtask

   task automatic drv(input logic v, input int rs1, input logic u1, input int rs2, input logic u2,
                      input int rd, input logic mr, input logic br, input logic fz);
      IFID_valid = v;
      IFID_Reg_Rs1 = RW'(rs1); IFID_Rs1_used = u1;
      IFID_Reg_Rs2 = RW'(rs2); IFID_Rs2_used = u2;
      IFID_Reg_Rd = RW'(rd); IFID_MemRead = mr;
      Branch_taken = br; Pipe_freeze = fz;
   endtask

   initial begin
      rst = 1'b1;
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
      model_reset();
      #2;
      check_now();
      @(posedge clk);
      #1;
      rst = 1'b0;
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0); cyc();

      // lw x7 then immediate consumer: two stall cycles
      drv(1, 1, 1, 2, 1, 7, 1, 0, 0); cyc();
      drv(1, 0, 0, 7, 1, 3, 0, 0, 0); cyc(); cyc();
      chk("two_stall_cnt", {28'd0, Stall_count}, 32'd2);
      cyc();
      // consumer one instruction later: one stall cycle
      drv(1, 1, 1, 2, 1, 7, 1, 0, 0); cyc();
      drv(1, 1, 1, 0, 0, 4, 0, 0, 0); cyc();
      drv(1, 0, 0, 7, 1, 3, 0, 0, 0); cyc(); cyc();
      chk("one_stall_cnt", {28'd0, Stall_count}, 32'd3);

      // x0 destination and unused source never stall
      drv(1, 1, 1, 2, 1, 0, 1, 0, 0); cyc();
      drv(1, 0, 1, 0, 1, 3, 0, 0, 0); cyc();
      drv(1, 1, 1, 2, 1, 9, 1, 0, 0); cyc();
      drv(1, 9, 0, 1, 1, 3, 0, 0, 0); cyc();
      chk("x0_unused_mux", {31'd0, Mux_select}, 32'd0);

      // branch and hazard together: flush wins, no stall counted
      drv(1, 1, 1, 2, 1, 5, 1, 0, 0); cyc();
      drv(1, 5, 1, 0, 0, 3, 0, 1, 0); #3;
      chk("br_haz_flush", {31'd0, IFID_flush}, 32'd1);
      chk("br_haz_pc",    {31'd0, PC_write},   32'd1);
      #1; @(posedge clk); #1; cyc_no++;
      ready_in[5] = (ready_in[5] > 0) ? ready_in[5] - 1 : 0;
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0); cyc(); cyc();
      chk("br_haz_cnt", {28'd0, Stall_count}, 32'd3);

      // freeze mid-stall: one stall, three frozen, one more stall, then issue
      drv(1, 1, 1, 2, 1, 6, 1, 0, 0); cyc();
      drv(1, 6, 1, 0, 0, 3, 0, 0, 0); cyc();
      drv(1, 6, 1, 0, 0, 3, 0, 0, 1); cyc(); cyc(); cyc();
      drv(1, 6, 1, 0, 0, 3, 0, 0, 0); #3;
      chk("frz_resume_mux", {31'd0, Mux_select}, 32'd1);
      #1; @(posedge clk); #1; cyc_no++;
      for (int r = 0; r < 32; r++) if (ready_in[r] > 0) ready_in[r]--;
      cnt_m++;
      cyc();
      chk("frz_cnt", {28'd0, Stall_count}, 32'd5);

      // asynchronous reset in the middle of a stall
      drv(1, 1, 1, 2, 1, 8, 1, 0, 0); cyc();
      drv(1, 8, 1, 0, 0, 3, 0, 0, 0); cyc();
      areset();
      chk("rst_cnt", {28'd0, Stall_count}, 32'd0);
      cyc();

      // saturation: 10 load/consumer pairs give 20 stalls on a 4-bit counter
      for (int i = 0; i < 10; i++) begin
         drv(1, 1, 1, 2, 1, 3, 1, 0, 0); cyc();
         drv(1, 3, 1, 0, 0, 4, 0, 0, 0); cyc(); cyc(); cyc();
      end
      chk("sat_cnt", {28'd0, Stall_count}, CMAX);

      areset();
      for (int i = 0; i < 600; i++) begin
         drv(($urandom_range(0, 99) < 85), $urandom_range(0, 3), $urandom_range(0, 1),
             $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
             ($urandom_range(0, 99) < 40), ($urandom_range(0, 99) < 8),
             ($urandom_range(0, 99) < 10));
         if ($urandom_range(0, 99) == 0) areset();
         else cyc();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
